// File: rtl/gcd_lcm_coproc.sv
`default_nettype none
// ============================================================================
// Module      : gcd_lcm_coproc
// Description : Memory-mapped GCD/LCM coprocessor on the core data bus.
//               GCD by repeated subtraction, LCM by add-and-compare of two
//               running multiples. Combinational read port muxed with dmem.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_lcm_coproc #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [2:0] C_OFF_OPA    = 3'd0;
    localparam logic [2:0] C_OFF_OPB    = 3'd1;
    localparam logic [2:0] C_OFF_CTRL   = 3'd2;
    localparam logic [2:0] C_OFF_STATUS = 3'd3;
    localparam logic [2:0] C_OFF_RESULT = 3'd4;

    state_t      state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] m1_q, m1_d;
    logic [31:0] m2_q, m2_d;
    logic [31:0] a_lat_q, a_lat_d;
    logic [31:0] b_lat_q, b_lat_d;
    logic        op_q, op_d;
    logic [31:0] fin_val_q, fin_val_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_abort;
    logic [32:0] w_m1_sum;
    logic [32:0] w_m2_sum;
    logic        unused_adr_bits;

    assign w_off     = DataAdr[4:2];
    assign Sel       = (DataAdr[31:5] == BASE_ADDR[31:5]);
    assign w_wr      = MemWrite && Sel;
    assign w_ctrl_wr = w_wr && (w_off == C_OFF_CTRL);
    assign w_start   = w_ctrl_wr && WriteData[0];
    assign w_abort   = w_ctrl_wr && WriteData[2];
    // 33-bit sums so the carry out flags an LCM that does not fit in 32 bits
    assign w_m1_sum  = {1'b0, m1_q} + {1'b0, a_lat_q};
    assign w_m2_sum  = {1'b0, m2_q} + {1'b0, b_lat_q};
    assign unused_adr_bits = ^DataAdr[1:0];

    assign Busy = busy_q;
    assign Done = done_q;

    // Register read mux; a same-cycle write is not visible until the next edge
    always_comb begin
        ReadData = '0;
        if (Sel) begin
            case (w_off)
                C_OFF_OPA:    ReadData = opa_q;
                C_OFF_OPB:    ReadData = opb_q;
                C_OFF_STATUS: ReadData = {29'd0, ovf_q, done_q, busy_q};
                C_OFF_RESULT: ReadData = result_q;
                default:      ReadData = '0;
            endcase
        end
    end

    // Next-state logic: operand writes, FSM sequencing, abort override last
    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        x_d        = x_q;
        y_d        = y_q;
        m1_d       = m1_q;
        m2_d       = m2_q;
        a_lat_d    = a_lat_q;
        b_lat_d    = b_lat_q;
        op_d       = op_q;
        fin_val_d  = fin_val_q;
        ovf_pend_d = ovf_pend_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ovf_d      = ovf_q;

        // Operand registers stay writable while a run uses its own copies
        if (w_wr && (w_off == C_OFF_OPA)) opa_d = WriteData;
        if (w_wr && (w_off == C_OFF_OPB)) opb_d = WriteData;

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    x_d        = opa_q;
                    y_d        = opb_q;
                    m1_d       = opa_q;
                    m2_d       = opb_q;
                    a_lat_d    = opa_q;
                    b_lat_d    = opb_q;
                    op_d       = WriteData[1];
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    ovf_pend_d = 1'b0;
                    if ((opa_q == 32'd0) || (opb_q == 32'd0)) begin
                        // Zero operand: GCD is the other value, LCM is zero
                        state_d   = ST_FIN;
                        fin_val_d = WriteData[1] ? 32'd0
                                  : ((opa_q == 32'd0) ? opb_q : opa_q);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!op_q) begin
                    if (x_q == y_q) begin
                        state_d   = ST_FIN;
                        fin_val_d = x_q;
                    end else if (x_q > y_q) begin
                        x_d = x_q - y_q;
                    end else begin
                        y_d = y_q - x_q;
                    end
                end else begin
                    if (m1_q == m2_q) begin
                        state_d   = ST_FIN;
                        fin_val_d = m1_q;
                    end else if (m1_q < m2_q) begin
                        if (w_m1_sum[32]) begin
                            state_d    = ST_FIN;
                            fin_val_d  = 32'd0;
                            ovf_pend_d = 1'b1;
                        end else begin
                            m1_d = w_m1_sum[31:0];
                        end
                    end else begin
                        if (w_m2_sum[32]) begin
                            state_d    = ST_FIN;
                            fin_val_d  = 32'd0;
                            ovf_pend_d = 1'b1;
                        end else begin
                            m2_d = w_m2_sum[31:0];
                        end
                    end
                end
            end
            ST_FIN: begin
                result_d = fin_val_q;
                ovf_d    = ovf_pend_q;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort beats start and any completion landing on the same edge
        if (w_abort) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
            ovf_d    = ovf_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            a_lat_q    <= '0;
            b_lat_q    <= '0;
            op_q       <= 1'b0;
            fin_val_q  <= '0;
            ovf_pend_q <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            x_q        <= x_d;
            y_q        <= y_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            a_lat_q    <= a_lat_d;
            b_lat_q    <= b_lat_d;
            op_q       <= op_d;
            fin_val_q  <= fin_val_d;
            ovf_pend_q <= ovf_pend_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/gcd_lcm_coproc.md
# gcd_lcm_coproc

Memory-mapped GCD/LCM coprocessor on the single-cycle RISC-V data bus, beside `dmem`. It decodes the core's `MemWrite`/`DataAdr`/`WriteData` to load two 32-bit operands and a command. It then runs an iterative subtract (GCD) or add-compare (LCM) loop over multiple cycles. Software polls status and reads the result through a combinational read port that the top level muxes with `dmem` read data.

## Interface
- `BASE_ADDR`, 32'h0000_0100: register window base; 32-byte aligned.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `MemWrite`  in  1  core store enable.
- `DataAdr`  in  32  core data address; byte address, word-aligned accesses only.
- `WriteData`  in  32  core store data.
- `ReadData`  out  32  combinational register read data for `DataAdr`; 0 when not selected.
- `Sel`  out  1  combinational; 1 when `DataAdr[31:5]==BASE_ADDR[31:5]`; top uses it to mux `ReadData` over `dmem`.
- `Busy`  out  1  registered; 1 while a computation runs.
- `Done`  out  1  registered; 1 from completion until the next accepted start.

## Operation
- Word offset is `DataAdr[4:2]`; `DataAdr[1:0]` ignored.
  - 0 OPA (RW)
  - 1 OPB (RW)
  - 2 CTRL (W: bit0 start, bit1 op {0 GCD, 1 LCM}, bit2 abort; reads 0)
  - 3 STATUS (R: bit0 Busy, bit1 Done, bit2 Ovf)
  - 4 RESULT (R)
  - 5-7 read 0; writes ignored.
- Writes take effect when `MemWrite && Sel` at a rising edge. Writes to STATUS and RESULT are ignored.
- OPA/OPB are always writable, including while busy. Working registers X, Y, M1, M2 are separate, so such writes affect only the next start.
- States: IDLE, RUN, FIN.
  - IDLE + start (abort=0): X←OPA, Y←OPB, M1←OPA, M2←OPB. Latch op. Busy←1, Done←0, Ovf←0. Go to RUN.
    - If OPA==0 or OPB==0: go to FIN directly with zero-case result. GCD returns the other operand (gcd(0,0)=0); LCM returns 0.
  - RUN, GCD, one step per cycle:
    - X==Y → FIN, result X.
    - X>Y → X←X−Y.
    - Else Y←Y−X.
  - RUN, LCM, one step per cycle:
    - M1==M2 → FIN, result M1.
    - M1<M2 → M1←M1+OPA_latched.
    - Else M2←M2+OPB_latched.
    - Additions are 33-bit. A carry out ends the run: FIN with result 0, Ovf←1.
  - FIN: RESULT←result, Busy←0, Done←1, go to IDLE. Takes one cycle.
- LCM uses latched copies of OPA/OPB captured at start.
- Start while Busy is ignored, whether in RUN or FIN.
- Abort (bit2=1) in any state: go to IDLE, Busy←0, Done←0. RESULT and Ovf are unchanged. Abort wins over start when both are set in one write.
- Non-CTRL writes never change state.

## Timing
- Reset values: `Busy`=0, `Done`=0, Ovf=0, RESULT=0, OPA=OPB=0, state IDLE. `ReadData`/`Sel` follow `DataAdr` combinationally even during reset; reads return reset values.
- Start edge E0: `Busy`=1 after E0.
  - Each RUN cycle does exactly one compare/step.
  - Equality seen on edge Ek moves to FIN; the next edge writes RESULT and drops `Busy`.
- Total cycles with `Busy`=1 is steps+2, where steps is the number of subtract/add operations.
  - Zero-operand case: `Busy`=1 for exactly 1 cycle.
- RESULT, Done, Ovf update on the same edge. A STATUS read in the following cycle sees Done=1.
- Reads are combinational in the same cycle as `DataAdr` (matches `dmem`). A read in the same cycle as a write to the same register returns the old value.
- Reset asserted mid-computation: immediate return to reset values, no completion.
- No iteration bound. Software uses abort to escape long runs.

## Test plan
- Reset mid-RUN of gcd(1,0xFFFF_FFFF) → Busy/Done/RESULT=0 immediately; a new gcd(12,8) then completes with RESULT=4.
- Store OPA=12, OPB=8, CTRL=1 → Busy=1 for 4 cycles (2 steps); RESULT=4, STATUS=0b010.
- OPA=4, OPB=6, CTRL=3 → LCM; Busy=1 for 5 cycles (3 steps); RESULT=12, Ovf=0.
- OPA=0, OPB=9: GCD → 9, LCM → 0, each after 1 busy cycle.
- LCM of 0xFFFF_FFFF and 0xFFFF_FFFE → Ovf=1, RESULT=0, Done=1.
- gcd(1,0xFFFF_FFFF) started; write OPA=99 and a second start while busy (both ignored by the run); then CTRL=4 abort → Busy=0 next cycle, Done=0, RESULT unchanged, OPA reads 99. Also check a read at unmapped offset 6 returns 0 with Sel=1.
